// File: rtl/s832a_bist_pkg.sv
// rtl/s832a_bist_pkg.sv - shared types, widths, taps and pin indices for the s832a BIST driver
package s832a_bist_pkg;

  localparam int PI_W    = 18;
  localparam int PO_W    = 19;
  localparam int G18_BIT = 17;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    INIT = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_e;

  // x^18+x^11+1 taps bits 17,10; x^19+x^6+x^2+x+1 taps bits 18,5,1,0
  localparam logic [PI_W-1:0] LFSR_TAPS = 18'h20400;
  localparam logic [PO_W-1:0] MISR_TAPS = 19'h40023;

  localparam int PI_G0   = 0;
  localparam int PI_G16  = 16;
  localparam int PI_G18  = G18_BIT;
  localparam int PO_G288 = 0;
  localparam int PO_G55  = 18;

  localparam logic [PI_W-1:0] INIT_VEC = PI_W'(1) << PI_G18;

  function automatic logic [PI_W-1:0] lfsr_next(input logic [PI_W-1:0] v);
    return {v[PI_W-2:0], ^(v & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/s832a_misr.sv
// rtl/s832a_misr.sv - PO_W-wide multiple-input signature register with load and enable
module s832a_misr
  import s832a_bist_pkg::*;
#(
  parameter logic [PO_W-1:0] RST_VAL = 19'h00001
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            load_i,
  input  logic            en_i,
  input  logic [PO_W-1:0] seed_i,
  input  logic [PO_W-1:0] data_i,
  output logic [PO_W-1:0] sig_o
);

  logic [PO_W-1:0] sig_q;
  logic [PO_W-1:0] sig_d;

  assign sig_d = {sig_q[PO_W-2:0], ^(sig_q & MISR_TAPS)} ^ data_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sig_q <= RST_VAL;
    end else if (load_i) begin
      sig_q <= seed_i;
    end else if (en_i) begin
      sig_q <= sig_d;
    end
  end

  assign sig_o = sig_q;

endmodule

// File: rtl/s832a_bist_driver.sv
// rtl/s832a_bist_driver.sv - BIST stimulus LFSR, run FSM and MISR response compactor for s832a
module s832a_bist_driver
  import s832a_bist_pkg::*;
#(
  parameter int unsigned      N_VEC     = 256,
  parameter logic [PI_W-1:0]  LFSR_SEED = 18'h00001,
  parameter logic [PO_W-1:0]  MISR_SEED = 19'h00001,
  parameter logic [PO_W-1:0]  EXP_SIG   = 19'h00000
) (
  input  logic            CK,
  input  logic            RN,
  input  logic            start,
  input  logic            abort,
  output logic [PI_W-1:0] pi_o,
  input  logic [PO_W-1:0] po_i,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [PO_W-1:0] sig_o
);

  localparam logic [PI_W-1:0] SEED_EFF = (LFSR_SEED == '0) ? 18'h00001 : LFSR_SEED;
  localparam logic [15:0]     LAST_CNT = 16'(N_VEC - 1);

  state_e          state_q;
  logic [PI_W-1:0] lfsr_q;
  logic [PI_W-1:0] lfsr_d;
  logic [15:0]     count_q;
  logic [PI_W-1:0] pi_q;
  logic            busy_q;
  logic            done_q;
  logic            misr_load;
  logic            misr_en;

  assign lfsr_d    = lfsr_next(lfsr_q);
  assign misr_load = ((state_q == IDLE) || (state_q == DONE)) && start;
  assign misr_en   = (state_q == RUN) && !abort;

  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      state_q <= IDLE;
      lfsr_q  <= SEED_EFF;
      count_q <= '0;
      pi_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_q <= INIT;
            lfsr_q  <= SEED_EFF;
            count_q <= '0;
            pi_q    <= INIT_VEC;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
          end
        end
        INIT: begin
          if (abort) begin
            state_q <= IDLE;
            pi_q    <= '0;
            busy_q  <= 1'b0;
          end else begin
            state_q <= RUN;
            pi_q    <= lfsr_q;
          end
        end
        RUN: begin
          if (abort) begin
            state_q <= IDLE;
            pi_q    <= '0;
            busy_q  <= 1'b0;
          end else begin
            lfsr_q  <= lfsr_d;
            count_q <= count_q + 16'd1;
            if (count_q == LAST_CNT) begin
              state_q <= DONE;
              pi_q    <= '0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              pi_q    <= lfsr_d;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          pi_q    <= '0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  // po_i is sampled in the same RUN cycle its vector is driven
  s832a_misr #(
    .RST_VAL (MISR_SEED)
  ) u_misr (
    .clk_i  (CK),
    .rst_ni (RN),
    .load_i (misr_load),
    .en_i   (misr_en),
    .seed_i (MISR_SEED),
    .data_i (po_i),
    .sig_o  (sig_o)
  );

  assign pi_o = pi_q;
  assign busy = busy_q;
  assign done = done_q;
  assign pass = done_q && (sig_o == EXP_SIG);

endmodule

// File: tb/tb_s832a_bist_driver.sv
// tb/tb_s832a_bist_driver.sv - self-checking bench for s832a_bist_driver
module tb_s832a_bist_driver;

  localparam int          NV_M  = 12;
  localparam logic [18:0] EXP_M = 19'h12345;

  logic CK = 1'b0;
  logic RN = 1'b1;
  always #5 CK = ~CK;

  logic        start_m, abort_m, start_ab;
  logic [17:0] pi_m, pi_p, pi_f;
  logic [18:0] po_m, sig_m, sig_p, sig_f;
  logic        busy_m, done_m, pass_m;
  logic        busy_p, done_p, pass_p, busy_f, done_f, pass_f;
  logic        cmp_en;

  int checks = 0;
  int errors = 0;

  function automatic logic [18:0] fake_ctrl(input logic [17:0] p);
    return {^p, p ^ {p[0], p[17:1]}};
  endfunction

  function automatic logic [18:0] mstep(input logic [18:0] m, input logic [18:0] d);
    return {m[17:0], m[18] ^ m[5] ^ m[1] ^ m[0]} ^ d;
  endfunction

  assign po_m = fake_ctrl(pi_m);

  s832a_bist_driver #(.N_VEC(NV_M), .LFSR_SEED(18'h0), .MISR_SEED(19'h1), .EXP_SIG(EXP_M)) dut (
    .CK(CK), .RN(RN), .start(start_m), .abort(abort_m), .pi_o(pi_m), .po_i(po_m),
    .busy(busy_m), .done(done_m), .pass(pass_m), .sig_o(sig_m));

  s832a_bist_driver #(.N_VEC(4), .LFSR_SEED(18'h1), .MISR_SEED(19'h1), .EXP_SIG(19'h1B)) dut_p (
    .CK(CK), .RN(RN), .start(start_ab), .abort(1'b0), .pi_o(pi_p), .po_i(19'h0),
    .busy(busy_p), .done(done_p), .pass(pass_p), .sig_o(sig_p));

  s832a_bist_driver #(.N_VEC(4), .LFSR_SEED(18'h1), .MISR_SEED(19'h1), .EXP_SIG(19'h1C)) dut_f (
    .CK(CK), .RN(RN), .start(start_ab), .abort(1'b0), .pi_o(pi_f), .po_i(19'h0),
    .busy(busy_f), .done(done_f), .pass(pass_f), .sig_o(sig_f));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Model: phase 0 idle, 1 init, 2 run, 3 done; vector list precomputed from the polynomial
  logic [17:0] m_vec [NV_M];
  int          m_ph, m_idx;
  logic [18:0] m_misr;
  logic        m_pass;

  initial begin
    logic [17:0] v;
    v = 18'h1;
    for (int i = 0; i < NV_M; i++) begin
      m_vec[i] = v;
      v = {v[16:0], v[17] ^ v[10]};
    end
  end

  always @(posedge CK or negedge RN) begin
    if (!RN) begin
      m_ph <= 0; m_idx <= 0; m_misr <= 19'h1; m_pass <= 1'b0;
    end else begin
      case (m_ph)
        0, 3: if (start_m) begin
          m_ph <= 1; m_idx <= 0; m_misr <= 19'h1; m_pass <= 1'b0;
        end
        1: m_ph <= abort_m ? 0 : 2;
        2: if (abort_m) begin
          m_ph <= 0; m_pass <= 1'b0;
        end else begin
          m_misr <= mstep(m_misr, fake_ctrl(m_vec[m_idx]));
          m_idx  <= m_idx + 1;
          if (m_idx == NV_M - 1) begin
            m_ph   <= 3;
            m_pass <= (mstep(m_misr, fake_ctrl(m_vec[m_idx])) == EXP_M);
          end
        end
        default: m_ph <= 0;
      endcase
    end
  end

  always @(negedge CK) begin
    if (cmp_en) begin
      logic [17:0] e_pi;
      e_pi = (m_ph == 1) ? 18'h20000 : (m_ph == 2) ? m_vec[m_idx] : 18'h0;
      chk("model_pi", pi_m, e_pi);
      chk("model_busy", busy_m, (m_ph == 1 || m_ph == 2));
      chk("model_done", done_m, (m_ph == 3));
      chk("model_pass", pass_m, m_pass);
      chk("model_sig", sig_m, m_misr);
    end
  end

  task automatic wait_done(input int lim);
    int n;
    n = 0;
    while (!done_m && n < lim) begin
      @(negedge CK);
      n++;
    end
    chk("done_timeout", done_m, 1);
  endtask

  logic [18:0] steps [4];
  logic [18:0] gold;

  initial begin
    steps = '{19'h3, 19'h6, 19'hD, 19'h1B};
    start_m = 0; abort_m = 0; start_ab = 0; cmp_en = 0;
    #3 RN = 0;
    @(negedge CK); @(negedge CK);
    chk("rst_pi", pi_m, 0);
    chk("rst_busy", busy_m, 0);
    chk("rst_done", done_m, 0);
    chk("rst_pass", pass_m, 0);
    chk("rst_sig", sig_m, 19'h1);
    chk("rst_sig_p", sig_p, 19'h1);
    cmp_en = 1; RN = 1;

    start_m = 1; start_ab = 1;
    for (int c = 1; c <= 16; c++) begin
      @(negedge CK);
      start_m = 0; start_ab = 0;
      if (c == 1)  chk("init_vec", pi_m, 18'h20000);
      if (c == 1)  chk("init_vec_p", pi_p, 18'h20000);
      if (c == 2)  chk("vec1", pi_m, 18'h1);
      if (c == 12) chk("vec11", pi_m, 18'h400);
      if (c == 13) chk("vec12", pi_m, 18'h801);
      if (c == 13) chk("not_done_early", done_m, 0);
      if (c == 14) chk("done_at_n_plus_2", done_m, 1);
      if (c >= 3 && c <= 6) chk("sig_step", sig_p, steps[c-3]);
      if (c == 5) chk("not_done_p", done_p, 0);
      if (c == 6) begin
        chk("done_p", done_p, 1);
        chk("pass_p", pass_p, 1);
        chk("done_f", done_f, 1);
        chk("pass_f", pass_f, 0);
      end
      if (c == 16) begin
        chk("held_sig_f", sig_f, 19'h1B);
        chk("held_done_f", done_f, 1);
        chk("held_pass_f", pass_f, 0);
      end
    end
    gold = m_misr;

    start_m = 1;
    for (int c = 1; c <= 5; c++) begin
      @(negedge CK);
      start_m = (c == 3);
      if (c == 5) chk("ign_start_vec", pi_m, 18'h8);
    end
    start_m = 0;
    wait_done(20);
    chk("rerun_sig", sig_m, gold);

    start_m = 1;
    @(negedge CK);
    start_m = 0;
    chk("done_restart_done", done_m, 0);
    chk("done_restart_pi", pi_m, 18'h20000);
    @(negedge CK); @(negedge CK);
    abort_m = 1;
    @(negedge CK);
    abort_m = 0;
    chk("abort_busy", busy_m, 0);
    chk("abort_done", done_m, 0);
    chk("abort_pi", pi_m, 0);
    abort_m = 1;
    @(negedge CK);
    abort_m = 0;
    chk("abort_idle_busy", busy_m, 0);

    start_m = 1;
    @(negedge CK);
    start_m = 0;
    chk("restart_init", pi_m, 18'h20000);
    wait_done(20);
    chk("restart_sig", sig_m, gold);

    start_m = 1;
    @(negedge CK);
    start_m = 0;
    repeat (4) @(negedge CK);
    #2 RN = 0;
    #1;
    chk("midrst_pi", pi_m, 0);
    chk("midrst_busy", busy_m, 0);
    chk("midrst_done", done_m, 0);
    chk("midrst_sig", sig_m, 19'h1);
    @(negedge CK);
    RN = 1;

    start_m = 1;
    @(negedge CK);
    start_m = 0;
    wait_done(20);
    start_m = 1; abort_m = 1;
    @(negedge CK);
    start_m = 0; abort_m = 0;
    chk("dual_in_done", busy_m, 1);
    @(negedge CK);
    start_m = 1; abort_m = 1;
    @(negedge CK);
    start_m = 0; abort_m = 0;
    chk("dual_in_run", busy_m, 0);
    repeat (3) @(negedge CK);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
